meas_mode_ctrl: RTL and testbench

//  Central sequencer for the voltmeter datapath.
//  - Paces ADC conversions (adc_start strobe).
//  - Runs the LIVE/HOLD/AVERAGE mode FSM from the debounced hold/release ticks.
//  - Block-averages samples in AVERAGE mode.
//  - Presents one 12-bit display code plus an update strobe to binary_to_BCD.
//  - Sits between the ADC controller, the debouncers and the BCD/7-seg chain.
//  - Replaces the separate timer and adder_acumulator sequencing.

---
 rtl/meas_mode_ctrl.sv | 131 +++++++++++++
 tb/tb_meas_mode_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/meas_mode_ctrl.sv
// Voltmeter sequencer: paces ADC starts, runs the LIVE/HOLD/AVG display FSM and block-averages samples.
// Latency: 1 cycle from an accepted sample to the disp_value/disp_update change. No backpressure: skipped starts are dropped, never queued.
module meas_mode_ctrl #(
  parameter int SAMPLE_PERIOD = 50000,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT       = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_tick,
  input  logic        release_tick,
  input  logic        sample_valid,
  input  logic [11:0] sample,
  output logic        adc_start,
  output logic [11:0] disp_value,
  output logic        disp_update,
  output logic        LED_hold,
  output logic        LED_average,
  output logic        adc_err
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int BW = $clog2(TIMEOUT + 1);
  localparam int AW = 12 + AVG_LOG2;
  localparam logic [PW-1:0]       PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [BW-1:0]       BUSY_LAST   = BW'(TIMEOUT - 1);
  localparam logic [AVG_LOG2-1:0] AVG_LAST    = '1;

  typedef enum logic [1:0] {LIVE, HOLD, AVG} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PW-1:0]       period_cnt;
  logic [BW-1:0]       busy_cnt;
  logic                busy;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_sum;
  logic [AVG_LOG2-1:0] avg_cnt;
  logic                wrap;
  logic                accept;
  logic                timeout_hit;
  logic                start_now;
  logic                block_done;

  assign wrap        = (period_cnt == PERIOD_LAST);
  assign accept      = sample_valid & busy;
  assign timeout_hit = busy & ~accept & (busy_cnt == BUSY_LAST);
  // A conversion finishing on the wrap cycle frees the slot for the new start.
  assign start_now   = wrap & (~busy | accept | timeout_hit);
  assign acc_sum     = acc + AW'(sample);
  assign block_done  = accept & (state == AVG) & (avg_cnt == AVG_LAST);

  always_comb begin
    state_nxt = state;
    if (release_tick) begin
      state_nxt = LIVE;
    end else if (hold_tick) begin
      case (state)
        LIVE:    state_nxt = HOLD;
        HOLD:    state_nxt = AVG;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LIVE;
      LED_hold    <= 1'b0;
      LED_average <= 1'b0;
    end else begin
      state       <= state_nxt;
      LED_hold    <= (state_nxt == HOLD);
      LED_average <= (state_nxt == AVG);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      busy_cnt   <= '0;
      busy       <= 1'b0;
      adc_start  <= 1'b0;
      adc_err    <= 1'b0;
    end else begin
      period_cnt <= wrap ? '0 : period_cnt + 1'b1;
      adc_start  <= start_now;
      if (start_now) begin
        busy     <= 1'b1;
        busy_cnt <= '0;
      end else if (accept | timeout_hit) begin
        busy     <= 1'b0;
      end else if (busy) begin
        busy_cnt <= busy_cnt + 1'b1;
      end
      // A timeout landing with a release still leaves the flag set so the event is not lost.
      if (timeout_hit) begin
        adc_err <= 1'b1;
      end else if (release_tick) begin
        adc_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_value  <= '0;
      disp_update <= 1'b0;
      acc         <= '0;
      avg_cnt     <= '0;
    end else begin
      disp_update <= 1'b0;
      if (accept && state == LIVE) begin
        disp_value  <= sample;
        disp_update <= 1'b1;
      end else if (block_done) begin
        disp_value  <= acc_sum[AW-1:AVG_LOG2];
        disp_update <= 1'b1;
      end

      if (release_tick || (state == HOLD && hold_tick) || block_done) begin
        acc     <= '0;
        avg_cnt <= '0;
      end else if (accept && state == AVG) begin
        acc     <= acc_sum;
        avg_cnt <= avg_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_meas_mode_ctrl.sv
// Bench for meas_mode_ctrl: directed table, hand-written corner sequences and a random run against an event-level model.
module tb_meas_mode_ctrl;

  localparam int SP       = 32;
  localparam int AVG_LOG2 = 2;
  localparam int TO       = 64;
  localparam int NAVG     = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold_tick = 1'b0;
  logic        release_tick = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic        adc_start;
  logic [11:0] disp_value;
  logic        disp_update;
  logic        LED_hold;
  logic        LED_average;
  logic        adc_err;

  int checks = 0;
  int failures = 0;

  meas_mode_ctrl #(.SAMPLE_PERIOD(SP), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .hold_tick(hold_tick), .release_tick(release_tick),
    .sample_valid(sample_valid), .sample(sample), .adc_start(adc_start),
    .disp_value(disp_value), .disp_update(disp_update), .LED_hold(LED_hold),
    .LED_average(LED_average), .adc_err(adc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: counts edges since reset, tracks the outstanding conversion by
  // its start edge and keeps the average block as a queue of raw samples.
  localparam int M_LIVE = 0, M_HOLD = 1, M_AVG = 2;
  int          cyc, ts, mode, sum;
  bit          m_busy, m_err, m_start, m_upd, acc_ok, tmo;
  logic [11:0] m_disp;
  int          q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; ts = 0; mode = M_LIVE; m_busy = 0; m_err = 0; m_start = 0; m_upd = 0;
      m_disp = '0; q.delete();
    end else begin
      cyc++;
      acc_ok  = sample_valid && m_busy;
      tmo     = m_busy && !acc_ok && (cyc - ts == TO);
      m_start = (cyc % SP == 0) && (!m_busy || acc_ok || tmo);
      if (m_start) begin
        m_busy = 1; ts = cyc;
      end else if (acc_ok || tmo) begin
        m_busy = 0;
      end
      if (tmo) m_err = 1;
      else if (release_tick) m_err = 0;
      m_upd = 0;
      if (acc_ok && mode == M_LIVE) begin
        m_disp = sample; m_upd = 1;
      end else if (acc_ok && mode == M_AVG) begin
        q.push_back(int'(sample));
        if (q.size() == NAVG) begin
          sum = 0;
          foreach (q[i]) sum += q[i];
          m_disp = 12'(sum / NAVG); m_upd = 1;
          q.delete();
        end
      end
      if (release_tick) begin
        mode = M_LIVE; q.delete();
      end else if (hold_tick && mode == M_LIVE) begin
        mode = M_HOLD;
      end else if (hold_tick && mode == M_HOLD) begin
        mode = M_AVG; q.delete();
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model", {15'd0, adc_start, disp_value, disp_update, LED_hold, LED_average, adc_err},
        {15'd0, m_start, m_disp, m_upd, mode == M_HOLD, mode == M_AVG, m_err});
  end

  task automatic wait_start();
    bit seen = 0;
    for (int i = 0; i < 2 * SP + TO + 4 && !seen; i++) begin
      @(negedge clk);
      if (adc_start) seen = 1;
    end
    chk("wait_start", {31'd0, seen}, 32'd1);
  endtask

  task automatic apply(input logic h, input logic r, input logic v, input logic [11:0] s);
    hold_tick = h; release_tick = r; sample_valid = v; sample = s;
    @(negedge clk);
    hold_tick = 0; release_tick = 0; sample_valid = 0;
  endtask

  task automatic do_conv(input logic h, input logic r, input logic v, input logic [11:0] s);
    wait_start();
    repeat (2) @(negedge clk);
    apply(h, r, v, s);
  endtask

  typedef struct {
    logic h; logic r; logic v; logic [11:0] s;
    logic [11:0] disp; logic upd; logic lh; logic la;
  } vec_t;
  vec_t tbl[12];

  int first_start, err_at, second_start, pending;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 12'h123, 12'h123, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 12'h100, 12'h123, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 12'h200, 12'h123, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 12'h555, 12'h123, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 12'hFFF, 12'h123, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 12'hFFF, 12'h123, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 12'hFFF, 12'h123, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 12'hFFC, 12'hFFE, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 12'h010, 12'hFFE, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 12'h020, 12'hFFE, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 12'h777, 12'h777, 1'b1, 1'b0, 1'b0};

    #3;
    chk("rst_outputs", {15'd0, adc_start, disp_value, disp_update, LED_hold, LED_average, adc_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // No ADC response: start pacing, timeout, skipped start, start on timeout+wrap.
    first_start = -1; err_at = -1; second_start = -1;
    for (int k = 1; k <= SP + TO; k++) begin
      @(posedge clk); #1;
      if (adc_start && first_start < 0) first_start = k;
      else if (adc_start && second_start < 0) second_start = k;
      if (adc_err && err_at < 0) err_at = k;
    end
    chk("first_start", first_start, SP);
    chk("err_at", err_at, SP + TO);
    chk("second_start", second_start, SP + TO);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b1, 12'h000);
    chk("err_cleared", {31'd0, adc_err}, 32'd0);

    foreach (tbl[i]) begin
      do_conv(tbl[i].h, tbl[i].r, tbl[i].v, tbl[i].s);
      chk($sformatf("tbl%0d_disp", i), {20'd0, disp_value}, {20'd0, tbl[i].disp});
      chk($sformatf("tbl%0d_upd", i), {31'd0, disp_update}, {31'd0, tbl[i].upd});
      chk($sformatf("tbl%0d_leds", i), {30'd0, LED_hold, LED_average}, {30'd0, tbl[i].lh, tbl[i].la});
      chk($sformatf("tbl%0d_err", i), {31'd0, adc_err}, 32'd0);
    end

    // Sample lands on the wrap edge: new start issued immediately.
    wait_start();
    repeat (SP - 1) @(negedge clk);
    apply(1'b0, 1'b0, 1'b1, 12'h321);
    chk("wrap_sv_start", {31'd0, adc_start}, 32'd1);
    chk("wrap_sv_disp", {20'd0, disp_value}, 32'h321);
    // Unanswered conversion times out exactly on a wrap: error and new start together.
    repeat (TO) @(negedge clk);
    chk("wrap_tmo_start", {31'd0, adc_start}, 32'd1);
    chk("wrap_tmo_err", {31'd0, adc_err}, 32'd1);
    repeat (2) @(negedge clk);
    apply(1'b0, 1'b1, 1'b1, 12'h044);
    chk("tmo_release_err", {31'd0, adc_err}, 32'd0);
    chk("tmo_release_disp", {20'd0, disp_value}, 32'h044);

    // Reset mid-AVG with a conversion in flight.
    do_conv(1'b1, 1'b0, 1'b1, 12'h111);
    do_conv(1'b1, 1'b0, 1'b1, 12'h222);
    do_conv(1'b0, 1'b0, 1'b1, 12'h400);
    do_conv(1'b0, 1'b0, 1'b1, 12'h800);
    chk("pre_rst_avg", {31'd0, LED_average}, 32'd1);
    wait_start();
    @(negedge clk);
    rst_n = 0;
    #2;
    chk("midrst_outputs", {15'd0, adc_start, disp_value, disp_update, LED_hold, LED_average, adc_err}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    apply(1'b0, 1'b0, 1'b1, 12'hAAA);
    chk("late_sv_upd", {31'd0, disp_update}, 32'd0);
    chk("late_sv_disp", {20'd0, disp_value}, 32'd0);

    // Random run: responses with random latency (some late or missing), stray samples, random ticks.
    pending = -1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (adc_start && pending < 0 && $urandom_range(0, 9) != 0) pending = $urandom_range(0, TO + 8);
      sample_valid = (pending == 0) || ($urandom_range(0, 59) == 0);
      if (pending >= 0) pending--;
      sample       = 12'($urandom_range(0, 4095));
      hold_tick    = ($urandom_range(0, 79) == 0);
      release_tick = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    hold_tick = 0; release_tick = 0; sample_valid = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
